// File: rtl/gpib_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpib_pkg
//  Purpose  : Shared types and defaults for the GPIB talker source scheduler.
//             Holds the source-handshake state encoding and default widths.
//  Revision : 1.0  initial release
// ============================================================================
package gpib_pkg;

  localparam int GPIB_DATA_WIDTH     = 8;
  localparam int GPIB_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_WAIT_NRFD  = 3'd2,
    ST_WAIT_NDAC  = 3'd3,
    ST_WAIT_RESET = 3'd4
  } gpib_src_state_t;

endpackage
`default_nettype wire

// File: rtl/gpib_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpib_rr_arbiter
//  Purpose  : Combinational one-hot round-robin pick. Searches the request
//             vector starting at index ptr and wrapping; the pointer register
//             lives in the parent.
//  Ports    : req  [NUM_REQ]  request vector
//             ptr  [IDX_W]    index with highest priority
//             gnt  [NUM_REQ]  one-hot winner (all zero when no request)
//             idx  [IDX_W]    binary index of the winner
//             any             at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module gpib_rr_arbiter
  import gpib_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[IDX_W'(j)]) begin
        any              = 1'b1;
        gnt[IDX_W'(j)]   = 1'b1;
        idx              = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpib_source_sched.sv
`default_nettype none
// ============================================================================
//  Module   : gpib_source_sched
//  Purpose  : Shares the GPIB talker datapath among NUM_REQ byte sources with
//             round-robin arbitration and a per-message bus lock, and runs the
//             DAV/NRFD/NDAC source handshake for each byte.
//  Ports    : clk, rst (async, active-high)
//             talker_en              interface addressed as talker
//             req_valid/data/last    per-requester byte stream
//             req_ready              byte accepted this cycle
//             nrfd, ndac             listener handshake lines (1 = not ready /
//                                    not accepted)
//             bus_data, bus_oe, dav, eoi   talker pin drive
//             grant                  one-hot current owner
//             busy                   handshake in progress
//             timeout_err            one-cycle watchdog pulse
//  Config   : GPIB_HS_TIMEOUT_EN  builds the handshake watchdog
//             (TIMEOUT_CYCLES); without it timeout_err is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module gpib_source_sched
  import gpib_pkg::*;
#(
  parameter int DATA_WIDTH     = GPIB_DATA_WIDTH,
  parameter int NUM_REQ        = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = GPIB_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          talker_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          nrfd,
  input  logic                          ndac,
  output logic [DATA_WIDTH-1:0]         bus_data,
  output logic                          bus_oe,
  output logic                          dav,
  output logic                          eoi,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
`ifdef GPIB_HS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > $clog2(SETTLE_CYCLES + 1)) ?
                         $clog2(TIMEOUT_CYCLES + 1) : $clog2(SETTLE_CYCLES + 1);
`else
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
`endif

  // Zero-length settle or watchdog windows are not meaningful configurations.
  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
  end

  gpib_src_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_ptr;
  logic [NUM_REQ-1:0]      r_grant, w_grant_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_last;
  logic                    r_dav, r_oe, r_eoi;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_cnt_inc;
  logic                    w_can_accept, w_accept, w_tmo;
  logic [NUM_REQ-1:0]      w_arb_req, w_arb_gnt;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_any;

  // A held grant in IDLE is the burst lock: only the owner may be picked.
  assign w_arb_req = (|r_grant) ? (req_valid & r_grant) : req_valid;

  gpib_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (w_arb_req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  assign w_can_accept = (r_state == ST_IDLE) && talker_en;
  assign req_ready    = w_can_accept ? w_arb_gnt : '0;
  assign w_accept     = w_can_accept && w_arb_any;

`ifdef GPIB_HS_TIMEOUT_EN
  logic w_in_wait;
  assign w_in_wait = (r_state == ST_WAIT_NRFD) || (r_state == ST_WAIT_NDAC) ||
                     (r_state == ST_WAIT_RESET);
  assign w_cnt_inc = (r_state == ST_SETTLE) || w_in_wait;
`else
  assign w_cnt_inc = (r_state == ST_SETTLE);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETTLE;
          w_grant_nxt = w_arb_gnt;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_WAIT_NRFD;
      end
      ST_WAIT_NRFD: begin
        if (!nrfd) w_state_nxt = ST_WAIT_NDAC;
      end
      ST_WAIT_NDAC: begin
        if (!ndac) w_state_nxt = ST_WAIT_RESET;
      end
      ST_WAIT_RESET: begin
        if (ndac) begin
          w_state_nxt = ST_IDLE;
          if (r_last) w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
`ifdef GPIB_HS_TIMEOUT_EN
    if (talker_en && w_in_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = '0;
      w_tmo       = 1'b1;
    end
`endif
    // Losing the talker role silently discards the byte in flight.
    if ((r_state != ST_IDLE) && !talker_en) begin
      w_state_nxt = ST_IDLE;
      w_grant_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pin drives are registered from the next state so they change only on
  // clock edges and dav can never be high while bus_data is reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_dav   <= 1'b0;
      r_oe    <= 1'b0;
      r_eoi   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_dav   <= (w_state_nxt == ST_WAIT_NDAC);
      r_oe    <= (w_state_nxt != ST_IDLE);
      r_eoi   <= (w_state_nxt != ST_IDLE) &&
                 (w_accept ? req_last[w_arb_idx] : r_last);
      if (w_accept) begin
        r_data <= req_data[int'(w_arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        r_last <= req_last[w_arb_idx];
        r_ptr  <= (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + IDX_W'(1);
      end
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_inc)         r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef GPIB_HS_TIMEOUT_EN
  logic r_tmo;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tmo <= 1'b0;
    else     r_tmo <= w_tmo;
  end
  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus_data = r_data;
  assign bus_oe   = r_oe;
  assign dav      = r_dav;
  assign eoi      = r_eoi;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/gpib_source_sched.md
# gpib_source_sched

Round-robin scheduler that shares the GPIB talker datapath among NUM_REQ local byte sources and sequences the three-wire source handshake (DAV/NRFD/NDAC) for each byte. It sits between on-chip message producers and the GPIB bus pins. It is enabled only while the interface holds the talker role, and it locks the bus to one requester until that requester's message completes with EOI.

## Interface
- DATA_WIDTH, 8, bus byte width
- NUM_REQ, 4, number of requesters (2..8)
- SETTLE_CYCLES, 2, data-settling delay before DAV may assert (≥1)
- TIMEOUT_CYCLES, 1024, handshake watchdog limit (used only with the macro)

Ports. Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  async active-high reset
- talker_en  in  1  interface currently addressed as talker
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte is the message end (send with EOI)
- req_ready  out  NUM_REQ  byte accepted (transfer on valid&ready)
- nrfd  in  1  1 = some listener not ready
- ndac  in  1  1 = data not yet accepted
- bus_data  out  DATA_WIDTH  byte to the pins
- bus_oe  out  1  pin output enable
- dav  out  1  data valid
- eoi  out  1  end-or-identify, driven together with the last byte
- grant  out  NUM_REQ  one-hot current owner
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, SETTLE, WAIT_NRFD, WAIT_NDAC, WAIT_RESET.
- IDLE, no owner:
  - When talker_en && |req_valid, pick the winner round-robin, starting at the index after the last owner. After reset, index 0 has top priority.
  - req_ready[winner] is asserted combinationally in the same cycle.
  - Latch the byte and req_last, set grant, go to SETTLE.
- IDLE, owner held (burst lock):
  - Only the owner is considered. When its req_valid is high, accept the byte as above.
  - Other requesters wait.
- SETTLE:
  - bus_oe=1, bus_data=latched byte, eoi=latched last.
  - Count SETTLE_CYCLES cycles, then go to WAIT_NRFD.
- WAIT_NRFD: when nrfd is sampled 0, set dav=1 (registered) and go to WAIT_NDAC.
- WAIT_NDAC: when ndac is sampled 0, set dav=0 and go to WAIT_RESET.
- WAIT_RESET: when ndac is sampled 1, go to IDLE.
  - If the byte was last, clear grant.
  - Otherwise keep grant (burst lock).
  - bus_oe and eoi drop on entry to IDLE.
- talker_en low in any non-IDLE state:
  - Next cycle: dav=0, bus_oe=0, eoi=0, grant cleared, go to IDLE.
  - The accepted byte is discarded and no error is flagged.
- req_ready is never asserted while talker_en=0, and never outside IDLE.

## Timing
- Reset values: req_ready=0, bus_data=0, bus_oe=0, dav=0, eoi=0, grant=0, busy=0, timeout_err=0. The round-robin pointer points at index 0.
- Minimum byte cycle, with listeners responding instantly: 1 (accept) + SETTLE_CYCLES + 1 (dav rise) + 1 (dav fall) + 1 (ndac reset) = SETTLE_CYCLES+4 clocks.
- bus_data is stable from SETTLE entry until IDLE entry. dav is never high while bus_data changes.
- If nrfd=0 and ndac=0 together at WAIT_NRFD exit, wait in WAIT_NDAC for ndac 0 only after dav rises. Sampling is one cycle per state; no state is skipped.
- Reset mid-transfer releases dav and bus_oe asynchronously.

## Configuration
- GPIB_HS_TIMEOUT_EN defined:
  - A counter clears on each state entry and increments in WAIT_NRFD, WAIT_NDAC and WAIT_RESET.
  - At TIMEOUT_CYCLES: timeout_err pulses for 1 cycle, dav/bus_oe/eoi drop, grant clears, and the FSM goes to IDLE.
- GPIB_HS_TIMEOUT_EN undefined: the FSM waits indefinitely, timeout_err is tied 0, and no counter logic is built.

## Structure
- Shared package gpib_pkg:
  - state enum (gpib_src_state_t)
  - default DATA_WIDTH
  - TIMEOUT_CYCLES default
- Sub-module gpib_rr_arbiter: one-hot round-robin pick from a request vector and pointer. It is combinational, and the pointer register lives in the parent.

## Test plan
- Single byte: req 0 sends 0xA5 with last=1; listeners hold nrfd=0 and pulse ndac low 3 cycles after dav. Expect bus_data=0xA5, eoi=1, dav high until ndac=0, and grant cleared after WAIT_RESET.
- Fairness: req 1, 2 and 3 all valid with single-byte last messages. Expect grant order 1, 2, 3, then 1 again. Each byte takes 6 clocks with SETTLE_CYCLES=2.
- Burst lock: req 0 sends 0x10, 0x11, 0x12 (last on 0x12) while req 2 stays valid. Expect req 2 to get no grant until 0x12 completes.
- Slow listener: nrfd held 1 for 50 cycles. Expect dav held 0 and dav rising 1 cycle after nrfd falls.
- Abort: talker_en dropped during WAIT_NDAC. Expect dav=0, bus_oe=0 and grant=0 the next cycle, and timeout_err=0.
- Timeout (macro on, TIMEOUT_CYCLES=16): ndac stuck 1. Expect a timeout_err pulse 16 cycles after WAIT_NDAC entry, then the FSM in IDLE.
